// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Stage indices, the multi-cycle FSM encoding and the stall/bubble mask helpers.
package pipe_ctrl_pkg;

  localparam int STALL_W = 6;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  typedef logic [STALL_W-1:0] stall_bus_t;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_BUSY = 2'd1,
    MC_DONE = 2'd2
  } mc_state_e;

  // top == 0 means no stage is requesting a stall.
  function automatic stall_bus_t hold_mask(input logic [2:0] top);
    stall_bus_t m;
    m = '0;
    if (top != 3'd0) begin
      for (int i = 0; i < STALL_W; i++) m[i] = (i <= int'(top));
    end
    return m;
  endfunction

  function automatic stall_bus_t bubble_mask(input logic [2:0] top);
    stall_bus_t m;
    m = '0;
    if (top != 3'd0) m[int'(top) + 1] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages and the stall/flush controller.
// master = pipeline side raising requests, slave = the controller.
interface pipe_ctrl_if #(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
);
  import pipe_ctrl_pkg::*;

  logic              if_stall_req;
  logic              id_stall_req;
  logic              ex_mc_start;
  logic [CNT_W-1:0]  ex_mc_cycles;
  logic              mem_stall_req;
  logic              flush_req;

  stall_bus_t        stall;
  stall_bus_t        bubble;
  logic              flush;
  logic              ex_mc_busy;
  logic              ex_mc_done;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output if_stall_req, id_stall_req, ex_mc_start, ex_mc_cycles, mem_stall_req, flush_req,
    input  stall, bubble, flush, ex_mc_busy, ex_mc_done, stall_cycles
  );

  modport slave (
    input  if_stall_req, id_stall_req, ex_mc_start, ex_mc_cycles, mem_stall_req, flush_req,
    output stall, bubble, flush, ex_mc_busy, ex_mc_done, stall_cycles
  );

endinterface

// File: rtl/pipe_ctrl_mc_timer.sv
// Latency down-counter for multi-cycle EX operations.
// Clear beats load beats decrement; decrement stops at zero.
module mc_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                       cnt_d = '0;
    else if (load_i)                 cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0)   cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller: stall priority, NOP bubbles, flush broadcast,
// multi-cycle EX sequencing and a saturating stall-cycle counter.
//
// state   | meaning
// MC_IDLE | no multi-cycle op; a start pulse stalls EX and loads the timer
// MC_BUSY | op running; EX held while the timer is non-zero, done at zero
// MC_DONE | result valid but MEM is holding; wait for MEM to release
module pipe_ctrl #(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);
  import pipe_ctrl_pkg::*;

  mc_state_e         state_q, state_d;
  logic [PERF_W-1:0] perf_q, perf_d;

  logic              mc_start_ok;
  logic              tmr_zero;
  logic [CNT_W-1:0]  tmr_load_val;
  logic              ex_req;
  logic [2:0]        top_stg;

  stall_bus_t        stall_vec;
  stall_bus_t        bubble_vec;
  logic              flush_vec;
  logic              busy_vec;
  logic              done_vec;

  assign mc_start_ok  = bus.ex_mc_start && !bus.flush_req && (state_q == MC_IDLE);
  // Latency 0 behaves like latency 1: the start cycle alone covers it.
  assign tmr_load_val = (bus.ex_mc_cycles == '0) ? '0 : bus.ex_mc_cycles - CNT_W'(1);

  mc_timer #(.CNT_W(CNT_W)) u_mc_timer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (bus.flush_req),
    .load_i     (mc_start_ok),
    .load_val_i (tmr_load_val),
    .dec_i      (state_q == MC_BUSY),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MC_IDLE;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      perf_q  <= perf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush_req) begin
      state_d = MC_IDLE;
    end else begin
      case (state_q)
        MC_IDLE: if (bus.ex_mc_start) state_d = MC_BUSY;
        MC_BUSY: if (tmr_zero)        state_d = bus.mem_stall_req ? MC_DONE : MC_IDLE;
        MC_DONE: if (!bus.mem_stall_req) state_d = MC_IDLE;
        default: state_d = MC_IDLE;
      endcase
    end
  end

  assign ex_req = mc_start_ok || (state_q == MC_BUSY && !tmr_zero);

  always_comb begin
    top_stg = 3'd0;
    if (bus.mem_stall_req)     top_stg = 3'(STG_MEM);
    else if (ex_req)           top_stg = 3'(STG_EX);
    else if (bus.id_stall_req) top_stg = 3'(STG_ID);
    else if (bus.if_stall_req) top_stg = 3'(STG_IF);

    stall_vec  = '0;
    bubble_vec = '0;
    flush_vec  = 1'b0;
    done_vec   = 1'b0;
    busy_vec   = 1'b0;
    if (!rst) begin
      busy_vec = (state_q != MC_IDLE);
      if (bus.flush_req) begin
        flush_vec = 1'b1;
      end else begin
        stall_vec  = hold_mask(top_stg);
        bubble_vec = bubble_mask(top_stg);
        done_vec   = (state_q == MC_BUSY && tmr_zero) || (state_q == MC_DONE);
      end
    end
  end

  assign perf_d = (stall_vec[STG_PC] && perf_q != {PERF_W{1'b1}}) ? perf_q + PERF_W'(1) : perf_q;

  assign bus.stall        = stall_vec;
  assign bus.bubble       = bubble_vec;
  assign bus.flush        = flush_vec;
  assign bus.ex_mc_busy   = busy_vec;
  assign bus.ex_mc_done   = done_vec;
  assign bus.stall_cycles = rst ? '0 : perf_q;

endmodule
